// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between fetch (I) and memory-stage (D) requesters
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t state, state_nx;
  logic [3:0] lat_cnt, starve_cnt;
  logic owner_d, we_q, issue, pick_i, done;
  always_comb begin
    issue = reset && state == IDLE && (i_req || d_req);
    pick_i = i_req && (!d_req || starve_cnt == SMAX);
    i_gnt = issue && pick_i;
    d_gnt = issue && !pick_i;
    mem_en = issue;
    mem_we = d_gnt && d_we;
    mem_addr = i_gnt ? i_addr : d_gnt ? d_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    done = state == WAIT && lat_cnt == LAT;
    state_nx = issue ? WAIT : done ? IDLE : state;
    busy = state == WAIT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
      starve_cnt <= '0;
      owner_d <= 1'b0;
      we_q <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_rvalid <= done && !owner_d;
      d_rvalid <= done && owner_d;
      if (done && !owner_d) i_rdata <= mem_rdata;
      if (done && owner_d) d_rdata <= we_q ? '0 : mem_rdata;
      if (issue) begin
        lat_cnt <= 4'd1;
        owner_d <= !pick_i;
        we_q <= d_gnt && d_we;
      end else if (state == WAIT) lat_cnt <= done ? 4'd0 : lat_cnt + 4'd1;
      // fetch only counts as starved while it is actually waiting behind a D grant
      if (i_gnt || (d_gnt && !i_req)) starve_cnt <= '0;
      else if (d_gnt && starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;
  localparam int STARVE_MAX = 4;
  logic clk = 0, reset = 0;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  int errors = 0, checks = 0;
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h0000_5EED;
  endfunction
  // memory device: data for a read issued in cycle T is on mem_rdata during T+MEM_LAT
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] pipe [MEM_LAT];
  always @(posedge clk) begin
    for (int k = MEM_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= (mem_en && !mem_we) ? (dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr)) : 32'hBAD0_BAD0;
    if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = pipe[MEM_LAT-1];
  // reference model: one transaction occupies MEM_LAT+1 cycles, response lands at the end
  logic [31:0] m_mem [logic [31:0]];
  int m_wait = 0, m_resp_in = 0, m_starve = 0;
  logic m_resp_d = 0, m_i_rv = 0, m_d_rv = 0;
  logic [31:0] m_resp_data = 0, m_i_rd = 0, m_d_rd = 0;
  logic e_issue, e_i, e_d, e_we;
  logic [31:0] e_addr, e_wdata;
  assign e_issue = reset && m_wait == 0 && (i_req || d_req);
  assign e_i = e_issue && i_req && (!d_req || m_starve == STARVE_MAX);
  assign e_d = e_issue && !e_i;
  assign e_we = e_d && d_we;
  assign e_addr = e_i ? i_addr : e_d ? d_addr : 32'h0;
  assign e_wdata = e_d ? d_wdata : 32'h0;
  always @(posedge clk or negedge reset) begin
    logic iss, gi, gd, st;
    logic [31:0] a;
    iss = e_issue; gi = e_i; gd = e_d; st = e_we; a = e_addr;
    if (!reset) begin
      m_wait = 0; m_resp_in = 0; m_starve = 0;
      m_i_rv = 0; m_d_rv = 0; m_i_rd = 0; m_d_rd = 0;
    end else begin
      m_i_rv = 0; m_d_rv = 0;
      if (m_resp_in > 0) begin
        m_resp_in--;
        if (m_resp_in == 0) begin
          if (m_resp_d) begin m_d_rv = 1; m_d_rd = m_resp_data; end
          else begin m_i_rv = 1; m_i_rd = m_resp_data; end
        end
      end
      if (m_wait > 0) m_wait--;
      if (iss) begin
        m_wait = MEM_LAT; m_resp_in = MEM_LAT; m_resp_d = gd;
        m_resp_data = st ? 32'h0 : (m_mem.exists(a) ? m_mem[a] : init_val(a));
        if (st) m_mem[a] = d_wdata;
        m_starve = gi ? 0 : !i_req ? 0 : (m_starve < STARVE_MAX ? m_starve + 1 : STARVE_MAX);
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    i_req = 1; d_req = 1; i_addr = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({i_gnt, d_gnt, mem_en, busy, i_rvalid, d_rvalid} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {i_gnt, d_gnt, mem_en, busy, i_rvalid, d_rvalid}); end
    checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata, d_rdata); end
    @(posedge clk); #1;
    reset = 1; i_req = 0; d_req = 0;
  endtask
  task automatic test_i_read();
    i_addr = 32'h10; i_req = 1;
    @(negedge clk);
    checks++; if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h10) begin errors++; $display("FAIL iread_grant: got gnt/en/we %b addr %h want 1010 addr 10", {i_gnt, d_gnt, mem_en, mem_we}, mem_addr); end
    tick(); i_req = 0; i_addr = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (busy !== (c <= 2) || i_rvalid !== (c == 3) || mem_en !== 1'b0) begin errors++; $display("FAIL iread_t%0d: got busy %b rvalid %b en %b", c, busy, i_rvalid, mem_en); end
      checks++; if (c >= 3 && i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL iread_data_t%0d: got %h want deadbeef", c, i_rdata); end
      tick();
    end
  endtask
  task automatic test_both();
    d_addr = 32'h80; d_we = 0; d_req = 1; i_addr = 32'h10; i_req = 1;
    @(negedge clk);
    checks++; if ({i_gnt, d_gnt} !== 2'b01 || mem_addr !== 32'h80) begin errors++; $display("FAIL both_first: got gnt %b addr %h want 01 addr 80", {i_gnt, d_gnt}, mem_addr); end
    tick(); d_req = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++; if (i_gnt !== (c == 3) || d_rvalid !== (c == 3) || i_rvalid !== (c == 6) || d_gnt !== 1'b0) begin errors++; $display("FAIL both_t%0d: got ignt %b drv %b irv %b dgnt %b", c, i_gnt, d_rvalid, i_rvalid, d_gnt); end
      if (c == 3) begin
        checks++; if (d_rdata !== init_val(32'h80) || mem_addr !== 32'h10) begin errors++; $display("FAIL both_dresp: got rdata %h addr %h want %h addr 10", d_rdata, mem_addr, init_val(32'h80)); end
      end
      if (c == 6) begin
        checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL both_iresp: got %h want deadbeef", i_rdata); end
      end
      tick();
      if (c == 3) i_req = 0;
    end
  endtask
  task automatic test_store();
    d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678; d_req = 1;
    @(negedge clk);
    checks++; if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin errors++; $display("FAIL store_issue: got %b addr %h wdata %h", {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata); end
    tick(); d_req = 0; d_we = 0; d_wdata = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if (i_rvalid !== 1'b0 || d_rvalid !== (c == 3)) begin errors++; $display("FAIL store_t%0d: got irv %b drv %b", c, i_rvalid, d_rvalid); end
      if (c == 3) begin
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_ack_data: got %h want 0", d_rdata); end
      end
      tick();
    end
  endtask
  task automatic test_starve();
    int gc[$];
    bit gi[$];
    i_addr = 32'h40; d_addr = 32'h84; d_we = 0; i_req = 1; d_req = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin gc.push_back(c); gi.push_back(i_gnt); end
      tick();
    end
    i_req = 0; d_req = 0;
    repeat (MEM_LAT + 2) tick();
    checks++; if (gc.size() != 10) begin errors++; $display("FAIL starve_count: got %0d grants want 10", gc.size()); end
    for (int k = 0; k < gc.size() && k < 10; k++) begin
      checks++; if (gc[k] != k * (MEM_LAT + 1) || gi[k] != (k % (STARVE_MAX + 1) == STARVE_MAX)) begin errors++; $display("FAIL starve_grant%0d: got cycle %0d port %s want cycle %0d port %s", k, gc[k], gi[k] ? "I" : "D", k * (MEM_LAT + 1), (k % (STARVE_MAX + 1) == STARVE_MAX) ? "I" : "D"); end
    end
  endtask
  task automatic test_reset_mid();
    i_addr = 32'h10; i_req = 1;
    @(negedge clk);
    checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL rmid_grant: got %b want 1", i_gnt); end
    tick(); reset = 0; #1;
    checks++; if ({busy, i_rvalid, i_gnt, mem_en} !== 4'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rmid_async: got %b rdata %h/%h want 0000 0/0", {busy, i_rvalid, i_gnt, mem_en}, i_rdata, d_rdata); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if ({busy, i_rvalid, i_gnt, mem_en} !== 4'b0) begin errors++; $display("FAIL rmid_hold%0d: got %b want 0000", c, {busy, i_rvalid, i_gnt, mem_en}); end
    end
    @(posedge clk); #1; reset = 1;
    @(negedge clk);
    checks++; if (i_gnt !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL rmid_regrant: got %b addr %h want 1 addr 10", i_gnt, mem_addr); end
    tick(); i_req = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if (i_rvalid !== (c == 3)) begin errors++; $display("FAIL rmid_rv_t%0d: got %b", c, i_rvalid); end
      if (c == 3) begin
        checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_data: got %h want deadbeef", i_rdata); end
      end
      tick();
    end
  endtask
  task automatic test_withdraw();
    d_addr = 32'h88; d_we = 0; d_req = 1;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL wd_dgnt: got %b want 1", d_gnt); end
    tick(); d_req = 0; i_addr = 32'h30; i_req = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++; if ({i_gnt, mem_en, i_rvalid} !== 3'b0 || busy !== (c <= 2)) begin errors++; $display("FAIL wd_t%0d: got gnt/en/rv %b busy %b", c, {i_gnt, mem_en, i_rvalid}, busy); end
      tick();
      i_req = 0;
    end
  endtask
  task automatic test_random();
    logic gi, gd;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      checks++; if ({i_gnt, d_gnt, mem_en, mem_we, busy, i_rvalid, d_rvalid} !== {e_i, e_d, e_issue, e_we, m_wait > 0, m_i_rv, m_d_rv}) begin errors++; $display("FAIL rand_ctrl@%0d: got %b want %b", n, {i_gnt, d_gnt, mem_en, mem_we, busy, i_rvalid, d_rvalid}, {e_i, e_d, e_issue, e_we, m_wait > 0, m_i_rv, m_d_rv}); end
      checks++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin errors++; $display("FAIL rand_mem@%0d: got %h/%h want %h/%h", n, mem_addr, mem_wdata, e_addr, e_wdata); end
      checks++; if (i_rdata !== m_i_rd || d_rdata !== m_d_rd) begin errors++; $display("FAIL rand_rdata@%0d: got %h/%h want %h/%h", n, i_rdata, d_rdata, m_i_rd, m_d_rd); end
      gi = i_gnt; gd = d_gnt;
      tick();
      if (!(i_req && !gi && $urandom_range(7) != 0)) begin
        i_req = $urandom_range(1);
        i_addr = {24'h0, 2'($urandom_range(3)), 4'($urandom_range(15)), 2'b00};
      end
      if (!(d_req && !gd && $urandom_range(7) != 0)) begin
        d_req = $urandom_range(1);
        d_we = $urandom_range(2) == 0;
        d_addr = {24'h0, 2'($urandom_range(3)), 4'($urandom_range(15)), 2'b00};
        d_wdata = $urandom;
      end
    end
    i_req = 0; d_req = 0;
    repeat (MEM_LAT + 2) tick();
  endtask
  initial begin
    dev_mem[32'h10] = 32'hDEADBEEF;
    m_mem[32'h10] = 32'hDEADBEEF;
    test_reset();
    test_i_read();
    test_both();
    test_store();
    test_starve();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
